// File: rtl/pcie_cpl_tag_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcie_cpl_tag_tracker                                                       |
// | Tracks outstanding MemRd tags and returns each one to the tag keeper.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pcie_cpl_tag_tracker #(
    parameter int pTAGS = 256,
    parameter int pLENW = 11
) (
    input  logic        i_Clk,
    input  logic        i_ARst,
    input  logic        i_ExtTag,
    input  logic        i_IssueValid,
    input  logic [7:0]  i8_IssueTag,
    input  logic [9:0]  i10_IssueLen,
    input  logic        i_CplValid,
    input  logic [7:0]  i8_CplTag,
    input  logic [9:0]  i10_CplLen,
    input  logic [2:0]  i3_CplStatus,
    output logic        o_TagPush,
    output logic [7:0]  o8_TagReturned,
    output logic        o_CplDone,
    output logic        o_CplErr,
    output logic        o_Unexpected,
    output logic        o_IssueErr,
    output logic [8:0]  o9_Outstanding
);

    localparam logic [pLENW-1:0] c_MAXLEN = pLENW'(1024);
    localparam logic [8:0]       c_MAXCNT = 9'd256;

    logic [pTAGS-1:0] r_Valid;
    logic [pLENW-1:0] r_Rem [pTAGS];
    logic             r_ExtTag;
    logic             r_Hold;

    logic             r_S2Valid;
    logic [7:0]       r_S2Tag;
    logic [pLENW-1:0] r_S2Len;
    logic [2:0]       r_S2Status;
    logic             r_S2EntValid;
    logic [pLENW-1:0] r_S2EntRem;

    logic             r_TagPush, r_CplDone, r_CplErr, r_Unexpected, r_IssueErr;
    logic [7:0]       r_TagReturned;
    logic [8:0]       r_Outstanding;

    logic             w_Flush, w_IssueOk, w_IssueDup;
    logic [pLENW-1:0] w_IssueLen, w_CplLen;
    logic             w_Unexp, w_Push, w_Done, w_Err, w_WbEn, w_WbValid;
    logic [pLENW-1:0] w_WbRem;
    logic             w_RdValid;
    logic [pLENW-1:0] w_RdRem;

    assign w_Flush    = (i_ExtTag != r_ExtTag);
    assign w_IssueLen = (i10_IssueLen == 10'd0) ? c_MAXLEN : pLENW'(i10_IssueLen);
    assign w_CplLen   = (i10_CplLen == 10'd0) ? c_MAXLEN : pLENW'(i10_CplLen);
    assign w_IssueOk  = i_IssueValid && !r_Valid[i8_IssueTag] && !w_Flush;
    assign w_IssueDup = i_IssueValid && r_Valid[i8_IssueTag];

    // S2 decision; release cases all clear the entry and push exactly once
    always_comb begin
        w_Unexp   = 1'b0;
        w_Push    = 1'b0;
        w_Done    = 1'b0;
        w_Err     = 1'b0;
        w_WbEn    = 1'b0;
        w_WbValid = r_S2EntValid;
        w_WbRem   = r_S2EntRem;
        if (r_S2Valid) begin
            if ((!r_ExtTag && (r_S2Tag[7:5] != 3'd0)) || !r_S2EntValid) begin
                w_Unexp = 1'b1;
            end else begin
                w_WbEn = 1'b1;
                if (r_S2Status != 3'd0 || r_S2Len > r_S2EntRem) begin
                    w_WbValid = 1'b0;
                    w_Err     = 1'b1;
                    w_Push    = 1'b1;
                end else if (r_S2Len == r_S2EntRem) begin
                    w_WbValid = 1'b0;
                    w_Done    = 1'b1;
                    w_Push    = 1'b1;
                end else begin
                    w_WbRem = r_S2EntRem - r_S2Len;
                end
            end
        end
    end

    // S1 read with forwarding from the S2 write-back and a same-cycle issue
    always_comb begin
        w_RdValid = r_Valid[i8_CplTag];
        w_RdRem   = r_Rem[i8_CplTag];
        if (w_WbEn && r_S2Tag == i8_CplTag) begin
            w_RdValid = w_WbValid;
            w_RdRem   = w_WbRem;
        end else if (w_IssueOk && i8_IssueTag == i8_CplTag) begin
            w_RdValid = 1'b1;
            w_RdRem   = w_IssueLen;
        end
    end

    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            r_Valid <= '0;
        end else if (w_Flush) begin
            r_Valid <= '0;
        end else begin
            if (w_IssueOk) r_Valid[i8_IssueTag] <= 1'b1;
            if (w_WbEn)    r_Valid[r_S2Tag]     <= w_WbValid;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_IssueOk) r_Rem[i8_IssueTag] <= w_IssueLen;
        if (w_WbEn)    r_Rem[r_S2Tag]     <= w_WbRem;
    end

    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            r_ExtTag     <= 1'b0;
            r_Hold       <= 1'b0;
            r_S2Valid    <= 1'b0;
            r_S2Tag      <= 8'd0;
            r_S2Len      <= '0;
            r_S2Status   <= 3'd0;
            r_S2EntValid <= 1'b0;
            r_S2EntRem   <= '0;
        end else begin
            r_ExtTag     <= i_ExtTag;
            r_Hold       <= w_Flush;
            r_S2Valid    <= i_CplValid && !w_Flush;
            r_S2Tag      <= i8_CplTag;
            r_S2Len      <= w_CplLen;
            r_S2Status   <= i3_CplStatus;
            r_S2EntValid <= w_RdValid;
            r_S2EntRem   <= w_RdRem;
        end
    end

    // Strobes registered in the flush cycle and the one after are dropped
    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            r_TagPush     <= 1'b0;
            r_CplDone     <= 1'b0;
            r_CplErr      <= 1'b0;
            r_Unexpected  <= 1'b0;
            r_IssueErr    <= 1'b0;
            r_TagReturned <= 8'd0;
            r_Outstanding <= 9'd0;
        end else begin
            r_TagPush    <= w_Push && !w_Flush && !r_Hold;
            r_CplDone    <= w_Done && !w_Flush && !r_Hold;
            r_CplErr     <= w_Err && !w_Flush && !r_Hold;
            r_Unexpected <= w_Unexp && !w_Flush && !r_Hold;
            r_IssueErr   <= w_IssueDup && !w_Flush && !r_Hold;
            if (w_Push && !w_Flush && !r_Hold) r_TagReturned <= r_S2Tag;
            if (w_Flush) begin
                r_Outstanding <= 9'd0;
            end else if (w_IssueOk && !w_Push) begin
                if (r_Outstanding != c_MAXCNT) r_Outstanding <= r_Outstanding + 9'd1;
            end else if (!w_IssueOk && w_Push) begin
                if (r_Outstanding != 9'd0) r_Outstanding <= r_Outstanding - 9'd1;
            end
        end
    end

    assign o_TagPush      = r_TagPush && !w_Flush;
    assign o_CplDone      = r_CplDone && !w_Flush;
    assign o_CplErr       = r_CplErr && !w_Flush;
    assign o_Unexpected   = r_Unexpected && !w_Flush;
    assign o_IssueErr     = r_IssueErr && !w_Flush;
    assign o8_TagReturned = r_TagReturned;
    assign o9_Outstanding = r_Outstanding;

endmodule
`default_nettype wire

// File: tb/tb_pcie_cpl_tag_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pcie_cpl_tag_tracker                                                    |
// | Scoreboard bench: reference tag table predicts every strobe and push.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pcie_cpl_tag_tracker;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       extTag = 1'b0;
    logic       issueValid = 1'b0;
    logic [7:0] issueTag = 8'd0;
    logic [9:0] issueLen = 10'd0;
    logic       cplValid = 1'b0;
    logic [7:0] cplTag = 8'd0;
    logic [9:0] cplLen = 10'd0;
    logic [2:0] cplStatus = 3'd0;
    logic       oPush, oDone, oErr, oUnexp, oIssueErr;
    logic [7:0] oTag;
    logic [8:0] oOut;

    pcie_cpl_tag_tracker #(.pTAGS(256), .pLENW(11)) dut (
        .i_Clk(clk), .i_ARst(arst), .i_ExtTag(extTag),
        .i_IssueValid(issueValid), .i8_IssueTag(issueTag), .i10_IssueLen(issueLen),
        .i_CplValid(cplValid), .i8_CplTag(cplTag), .i10_CplLen(cplLen),
        .i3_CplStatus(cplStatus),
        .o_TagPush(oPush), .o8_TagReturned(oTag), .o_CplDone(oDone),
        .o_CplErr(oErr), .o_Unexpected(oUnexp), .o_IssueErr(oIssueErr),
        .o9_Outstanding(oOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         push;
        bit [7:0]   tag;
        bit         done;
        bit         err;
        bit         unexp;
        bit         ierr;
    } exp_t;

    exp_t q[$];
    bit   mValid[256];
    int   mRem[256];
    int   mCnt = 0;
    int   cyc = 0;
    int   nChk = 0;
    int   nPass = 0;
    bit   run = 1'b0;

    bit       eP, eD, eE, eU, eI;
    bit [7:0] eT;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int obs, input int exp);
        nChk++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, obs, exp, cyc);
    endtask

    // Every cycle the strobes must equal whatever the scoreboard says is due now
    always @(negedge clk) begin
        if (run) begin
            eP = 0; eD = 0; eE = 0; eU = 0; eI = 0; eT = 8'd0;
            while (q.size() > 0 && q[0].due <= cyc) begin
                eP |= q[0].push; eD |= q[0].done; eE |= q[0].err;
                eU |= q[0].unexp; eI |= q[0].ierr;
                if (q[0].push) eT = q[0].tag;
                void'(q.pop_front());
            end
            chk("strobes{push,done,err,unexp,ierr}",
                int'({oPush, oDone, oErr, oUnexp, oIssueErr}),
                int'({eP, eD, eE, eU, eI}));
            if (eP) chk("tag_returned", int'(oTag), int'(eT));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit [7:0] t, input int len);
        exp_t e;
        issueValid = 1'b1;
        issueTag   = t;
        issueLen   = len[9:0];
        if (mValid[t]) begin
            e = '{due: cyc + 1, push: 0, tag: 8'd0, done: 0, err: 0, unexp: 0, ierr: 1};
            q.push_back(e);
        end else begin
            mValid[t] = 1'b1;
            mRem[t]   = (len == 0) ? 1024 : len;
            mCnt++;
        end
        @(posedge clk); #1;
        issueValid = 1'b0;
    endtask

    task automatic cpl(input bit [7:0] t, input int len, input bit [2:0] st);
        exp_t e;
        int   l;
        l = (len == 0) ? 1024 : len;
        e = '{due: cyc + 2, push: 0, tag: t, done: 0, err: 0, unexp: 0, ierr: 0};
        cplValid  = 1'b1;
        cplTag    = t;
        cplLen    = len[9:0];
        cplStatus = st;
        if ((!extTag && t[7:5] != 3'd0) || !mValid[t]) begin
            e.unexp = 1;
        end else if (st != 3'd0 || l > mRem[t]) begin
            mValid[t] = 1'b0; e.err = 1; e.push = 1; mCnt--;
        end else if (l == mRem[t]) begin
            mValid[t] = 1'b0; e.done = 1; e.push = 1; mCnt--;
        end else begin
            mRem[t] -= l;
        end
        if (e.push || e.unexp) q.push_back(e);
        @(posedge clk); #1;
        cplValid = 1'b0;
    endtask

    task automatic setExt(input bit v);
        extTag = v;
        for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
        mCnt = 0;
        while (q.size() > 0 && q[0].due <= cyc + 2) void'(q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic chkCnt(input string name);
        idle(3);
        chk(name, int'(oOut), mCnt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin mValid[i] = 1'b0; mRem[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outstanding", int'(oOut), 0);
        chk("reset_strobes", int'({oPush, oDone, oErr, oUnexp, oIssueErr}), 0);
        chk("reset_tag", int'(oTag), 0);
        @(posedge clk); #1;
        arst = 1'b0;
        run  = 1'b1;
        idle(2);

        issue(8'h05, 16);
        chkCnt("cnt_after_issue_05");
        cpl(8'h05, 8, 3'd0);
        cpl(8'h05, 4, 3'd0);
        cpl(8'h05, 4, 3'd0);
        chkCnt("cnt_after_05_done");

        issue(8'h10, 0);
        cpl(8'h10, 512, 3'd0);
        cpl(8'h10, 512, 3'd0);
        idle(2);
        cpl(8'h10, 1, 3'd0);
        chkCnt("cnt_after_10");

        issue(8'h03, 8);
        cpl(8'h03, 8, 3'd1);
        idle(2);
        issue(8'h03, 4);
        cpl(8'h03, 6, 3'd0);
        chkCnt("cnt_after_03_errors");

        cpl(8'h40, 1, 3'd0);
        idle(2);
        setExt(1'b1);
        idle(3);
        issue(8'hFF, 1);
        cpl(8'hFF, 1, 3'd0);
        chkCnt("cnt_after_ff");

        issue(8'h07, 8);
        issue(8'h07, 3);
        chkCnt("cnt_after_dup_issue");
        cpl(8'h07, 8, 3'd0);
        chkCnt("cnt_after_07_done");

        // Interleaved tags at full rate, including a completion in the issue+1 cycle
        issue(8'h20, 6);
        issue(8'h21, 2);
        cpl(8'h20, 2, 3'd0);
        cpl(8'h21, 2, 3'd0);
        cpl(8'h20, 4, 3'd0);
        chkCnt("cnt_after_interleave");

        for (int t = 1; t <= 4; t++) issue(8'(t), 8);
        chkCnt("cnt_before_flush");
        setExt(1'b0);
        chkCnt("cnt_after_flush");
        for (int t = 1; t <= 4; t++) cpl(8'(t), 8, 3'd0);
        chkCnt("cnt_after_flush_cpls");

        issue(8'h09, 2);
        cpl(8'h09, 2, 3'd0);
        arst = 1'b1;
        run  = 1'b0;
        q.delete();
        for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
        mCnt = 0;
        @(negedge clk);
        chk("midreset_outstanding", int'(oOut), mCnt);
        chk("midreset_push", int'(oPush), 0);
        @(posedge clk); #1;
        arst = 1'b0;
        run  = 1'b1;
        chkCnt("cnt_after_midreset");
        cpl(8'h09, 2, 3'd0);
        idle(4);

        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
`default_nettype wire
